conv_accum: RTL and testbench
=============================

CONV_ACCUM -- requirements
Module: conv_accum

Interface
REQ-001 Parameter: WIN_LOG2, default 3, log2 of window length N = 2^WIN_LOG2 samples.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: ACC_iStart  input  1  request to open a new accumulation window.
REQ-005 Port: ACC_iValid  input  1  ACC_iData valid this cycle.
REQ-006 Port: ACC_iData  input  9  signed two's-complement sample from the upstream CONV stage (CONV_oData).
REQ-007 Port: ACC_oReady  output  1  block accepts a sample this cycle.
REQ-008 Port: ACC_iReady  input  1  downstream accepts the result this cycle.
REQ-009 Port: ACC_oValid  output  1  result outputs valid.
REQ-010 Port: ACC_oSum  output  9+WIN_LOG2  signed window sum.
REQ-011 Port: ACC_oMean  output  9  signed window mean.
REQ-012 Port: ACC_oCount  output  WIN_LOG2+1  samples accepted in the current window.

Function
REQ-013 The block SHALL implement a state machine with states IDLE=2'b00, ACCUM=2'b01 and DONE=2'b10; 2'b11 SHALL return to IDLE on the next edge.
REQ-014 A sample SHALL be accepted on a rising edge with ACC_iValid=1 and ACC_oReady=1.
REQ-015 ACC_oReady SHALL be 1 only in ACCUM; ACC_iValid SHALL be ignored in IDLE and DONE.
REQ-016 In IDLE, ACC_iStart=1 SHALL clear the accumulator and ACC_oCount and move to ACCUM on the same edge.
REQ-017 ACC_iStart SHALL be ignored in ACCUM.
REQ-018 Each accepted sample SHALL be sign-extended to 9+WIN_LOG2 bits and added to the accumulator, and ACC_oCount SHALL increment by 1 on the same edge.
REQ-019 Cycles with ACC_iValid=0 in ACCUM SHALL hold the accumulator and ACC_oCount.
REQ-020 The edge accepting the Nth sample SHALL move the block to DONE.
REQ-021 On that edge ACC_oSum SHALL be loaded with the final sum, including the Nth sample.
REQ-022 On that edge ACC_oMean SHALL be loaded with sum >>> WIN_LOG2, an arithmetic shift that floors toward -inf.
REQ-023 On that edge ACC_oValid SHALL go to 1.
REQ-024 The sum width SHALL make overflow impossible; for WIN_LOG2=3 the range is -2048..+2040.
REQ-025 In DONE, ACC_oValid, ACC_oSum, ACC_oMean and ACC_oCount SHALL hold until an edge with ACC_iReady=1.
REQ-026 On an edge in DONE with ACC_iReady=1 and ACC_iStart=0, the block SHALL go to IDLE and ACC_oValid SHALL fall.
REQ-027 On an edge in DONE with ACC_iReady=1 and ACC_iStart=1, the block SHALL go directly to ACCUM with ACC_oCount and the accumulator cleared (back-to-back windows).
REQ-028 ACC_oSum and ACC_oMean SHALL retain the last result outside DONE.
REQ-029 All outputs except ACC_oReady SHALL be registered.
REQ-030 ACC_oReady SHALL be decoded from the state register only.

Reset
REQ-031 reset=0 SHALL, without waiting for clk, force IDLE and drive all outputs to 0.
REQ-032 reset=0 SHALL, without waiting for clk, clear the accumulator and ACC_oCount.
REQ-033 Reset asserted mid-window SHALL discard the partial sum.
REQ-034 After reset rises, the first ACC_iStart SHALL be recognised on the first rising edge.

Verification
REQ-035 Hold reset=0 for 256 cycles: all outputs read 0 and ACC_oReady=0 throughout.
REQ-036 Start, then 8 consecutive samples of +1 (CONV result of 3 + -2): ACC_oValid=1 after the 8th accept, with ACC_oSum=8, ACC_oMean=1, ACC_oCount=8.
REQ-037 Two windows: 8 samples of -256 give ACC_oSum=-2048, ACC_oMean=-256; 8 samples of +255 give ACC_oSum=2040, ACC_oMean=255.
REQ-038 Samples {0,0,0,-1,0,0,0,0} with ACC_iValid gaps of 1-3 cycles: ACC_oCount holds during gaps; final ACC_oSum=-1, ACC_oMean=-1.
REQ-039 DONE with ACC_iReady=0 for 5 cycles: outputs held; then ACC_iReady=1 with ACC_iStart=1: the next cycle is ACCUM with ACC_oCount=0, ACC_oValid=0 and ACC_oReady=1.
REQ-040 reset=0 pulse after the 4th sample of a window: outputs go to 0 immediately; a new full window of +2 then gives ACC_oSum=16, ACC_oMean=2.

Source files
------------

// File: rtl/conv_accum.sv
// Windowed accumulator: sums 2^WIN_LOG2 signed 9-bit samples, then presents the
// sum and floor-mean with a valid/ready handshake, optionally restarting back-to-back.
module conv_accum #(
   parameter int WIN_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ACC_iStart,
   input  logic                  ACC_iValid,
   input  logic [8:0]            ACC_iData,
   output logic                  ACC_oReady,
   input  logic                  ACC_iReady,
   output logic                  ACC_oValid,
   output logic [9+WIN_LOG2-1:0] ACC_oSum,
   output logic [8:0]            ACC_oMean,
   output logic [WIN_LOG2:0]     ACC_oCount
);

   localparam int SUM_W = 9 + WIN_LOG2;
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACCUM   = 2'b01,
      DONE    = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t state, state_next;

   logic signed [SUM_W-1:0] acc;
   logic signed [SUM_W-1:0] sample_ext;
   logic signed [SUM_W-1:0] sum_next;
   logic signed [SUM_W-1:0] mean_full;
   logic accept;
   logic last;
   logic start_win;
   logic release_res;

   assign ACC_oReady  = (state == ACCUM);
   assign accept      = ACC_oReady & ACC_iValid;
   assign last        = accept && (ACC_oCount == LAST_IDX);
   assign release_res = (state == DONE) && ACC_iReady;
   assign start_win   = ((state == IDLE) && ACC_iStart) || (release_res && ACC_iStart);

   // Sign extension to SUM_W bits leaves no room for overflow over a full window.
   assign sample_ext = {{WIN_LOG2{ACC_iData[8]}}, ACC_iData};
   assign sum_next   = acc + sample_ext;
   assign mean_full  = sum_next >>> WIN_LOG2;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: state_next gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ACC_iStart) state_next = ACCUM;
         ACCUM:   if (last) state_next = DONE;
         DONE:    if (ACC_iReady) state_next = ACC_iStart ? ACCUM : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc        <= '0;
         ACC_oCount <= '0;
         ACC_oSum   <= '0;
         ACC_oMean  <= '0;
         ACC_oValid <= 1'b0;
      end else begin
         if (start_win) begin
            acc        <= '0;
            ACC_oCount <= '0;
         end else if (accept) begin
            acc        <= sum_next;
            ACC_oCount <= ACC_oCount + CNT_W'(1);
         end

         // Sum and mean are only loaded on the final accept, so they keep the
         // last result through IDLE and the following window.
         if (last) begin
            ACC_oSum   <= sum_next;
            ACC_oMean  <= mean_full[8:0];
            ACC_oValid <= 1'b1;
         end else if (release_res || (state == ILLEGAL)) begin
            ACC_oValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_accum.sv
// Self-checking bench for conv_accum: window results go through a scoreboard
// queue filled as samples are driven and drained when the DUT raises valid.
module tb_conv_accum;

   localparam int WIN_LOG2 = 3;
   localparam int N        = 1 << WIN_LOG2;
   localparam int SUM_W    = 9 + WIN_LOG2;

   typedef struct {
      int sum;
      int mean;
   } result_t;

   logic             clk;
   logic             reset;
   logic             ACC_iStart;
   logic             ACC_iValid;
   logic [8:0]       ACC_iData;
   logic             ACC_oReady;
   logic             ACC_iReady;
   logic             ACC_oValid;
   logic [SUM_W-1:0] ACC_oSum;
   logic [8:0]       ACC_oMean;
   logic [WIN_LOG2:0] ACC_oCount;

   result_t sb_q[$];
   int total;
   int bad;

   conv_accum #(.WIN_LOG2(WIN_LOG2)) dut (
      .clk        (clk),
      .reset      (reset),
      .ACC_iStart (ACC_iStart),
      .ACC_iValid (ACC_iValid),
      .ACC_iData  (ACC_iData),
      .ACC_oReady (ACC_oReady),
      .ACC_iReady (ACC_iReady),
      .ACC_oValid (ACC_oValid),
      .ACC_oSum   (ACC_oSum),
      .ACC_oMean  (ACC_oMean),
      .ACC_oCount (ACC_oCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_window(input int samples[N], input int gaps[N], input bit do_start);
      result_t exp;
      int s;
      s = 0;
      if (do_start) begin
         ACC_iStart = 1'b1;
         step();
         ACC_iStart = 1'b0;
      end
      total++;
      if (ACC_oReady !== 1'b1 || ACC_oCount !== '0) begin
         bad++;
         $display("FAIL win_open: ready=%b count=%0d, want ready=1 count=0", ACC_oReady, ACC_oCount);
      end
      for (int i = 0; i < N; i++) begin
         ACC_iData  = 9'(samples[i]);
         ACC_iValid = 1'b1;
         s += samples[i];
         step();
         ACC_iValid = 1'b0;
         ACC_iData  = 9'h0AA;
         total++;
         if (int'(ACC_oCount) !== i + 1) begin
            bad++;
            $display("FAIL count_inc: count=%0d, want %0d", ACC_oCount, i + 1);
         end
         for (int g = 0; g < gaps[i]; g++) begin
            step();
            total++;
            if (int'(ACC_oCount) !== i + 1) begin
               bad++;
               $display("FAIL count_gap: count=%0d, want %0d", ACC_oCount, i + 1);
            end
         end
      end
      exp.sum  = s;
      exp.mean = s >>> WIN_LOG2;
      sb_q.push_back(exp);
   endtask

   task automatic check_result(output result_t got_exp);
      int waited;
      waited = 0;
      got_exp.sum  = 0;
      got_exp.mean = 0;
      while (ACC_oValid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      total++;
      if (ACC_oValid !== 1'b1) begin
         bad++;
         $display("FAIL result_timeout: valid=%b after %0d cycles, want 1", ACC_oValid, waited);
         return;
      end
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL result_unexpected: valid=1 with empty scoreboard, want no result");
         return;
      end
      got_exp = sb_q.pop_front();
      total++;
      if (int'($signed(ACC_oSum)) !== got_exp.sum) begin
         bad++;
         $display("FAIL result_sum: got %0d, want %0d", $signed(ACC_oSum), got_exp.sum);
      end
      total++;
      if (int'($signed(ACC_oMean)) !== got_exp.mean) begin
         bad++;
         $display("FAIL result_mean: got %0d, want %0d", $signed(ACC_oMean), got_exp.mean);
      end
      total++;
      if (int'(ACC_oCount) !== N || ACC_oReady !== 1'b0) begin
         bad++;
         $display("FAIL result_count: count=%0d ready=%b, want count=%0d ready=0", ACC_oCount, ACC_oReady, N);
      end
   endtask

   task automatic release_to_idle();
      ACC_iReady = 1'b1;
      step();
      ACC_iReady = 1'b0;
      total++;
      if (ACC_oValid !== 1'b0 || ACC_oReady !== 1'b0) begin
         bad++;
         $display("FAIL release: valid=%b ready=%b, want valid=0 ready=0", ACC_oValid, ACC_oReady);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         step();
         total++;
         if ({ACC_oValid, ACC_oReady, ACC_oSum, ACC_oMean, ACC_oCount} !== '0) begin
            bad++;
            $display("FAIL reset_hold: cycle %0d valid=%b ready=%b sum=%h mean=%h count=%h, want all 0",
                     i, ACC_oValid, ACC_oReady, ACC_oSum, ACC_oMean, ACC_oCount);
         end
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_ones();
      int smp[N];
      int gap[N];
      result_t e;
      foreach (smp[i]) begin smp[i] = 3 + -2; gap[i] = 0; end
      run_window(smp, gap, 1'b1);
      check_result(e);
      release_to_idle();
   endtask

   task automatic test_extremes();
      int smp[N];
      int gap[N];
      result_t e;
      foreach (smp[i]) begin smp[i] = -256; gap[i] = 0; end
      run_window(smp, gap, 1'b1);
      check_result(e);
      release_to_idle();
      foreach (smp[i]) smp[i] = 255;
      run_window(smp, gap, 1'b1);
      check_result(e);
      release_to_idle();
   endtask

   task automatic test_gaps();
      int smp[N] = '{0, 0, 0, -1, 0, 0, 0, 0};
      int gap[N];
      result_t e;
      foreach (gap[i]) gap[i] = (i == N - 1) ? 0 : 1 + (i % 3);
      run_window(smp, gap, 1'b1);
      check_result(e);
      release_to_idle();
   endtask

   task automatic test_back_to_back();
      int smp[N] = '{7, -3, 100, -200, 55, 1, -9, 20};
      int seq[N];
      int gap[N];
      result_t e;
      foreach (gap[i]) begin gap[i] = 0; seq[i] = i + 1; end
      run_window(smp, gap, 1'b1);
      check_result(e);
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if (ACC_oValid !== 1'b1 || int'($signed(ACC_oSum)) !== e.sum ||
             int'($signed(ACC_oMean)) !== e.mean || int'(ACC_oCount) !== N) begin
            bad++;
            $display("FAIL done_hold: cycle %0d valid=%b sum=%0d mean=%0d count=%0d, want 1/%0d/%0d/%0d",
                     c, ACC_oValid, $signed(ACC_oSum), $signed(ACC_oMean), ACC_oCount, e.sum, e.mean, N);
         end
      end
      ACC_iReady = 1'b1;
      ACC_iStart = 1'b1;
      step();
      ACC_iReady = 1'b0;
      ACC_iStart = 1'b0;
      total++;
      if (ACC_oValid !== 1'b0 || ACC_oReady !== 1'b1 || ACC_oCount !== '0) begin
         bad++;
         $display("FAIL b2b_restart: valid=%b ready=%b count=%0d, want 0/1/0", ACC_oValid, ACC_oReady, ACC_oCount);
      end
      total++;
      if (int'($signed(ACC_oSum)) !== e.sum || int'($signed(ACC_oMean)) !== e.mean) begin
         bad++;
         $display("FAIL b2b_retain: sum=%0d mean=%0d, want %0d %0d", $signed(ACC_oSum), $signed(ACC_oMean), e.sum, e.mean);
      end
      run_window(seq, gap, 1'b0);
      check_result(e);
      release_to_idle();
   endtask

   task automatic test_reset_mid();
      int smp[N];
      int gap[N];
      result_t e;
      ACC_iStart = 1'b1;
      step();
      ACC_iStart = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ACC_iData  = 9'd2;
         ACC_iValid = 1'b1;
         step();
      end
      ACC_iValid = 1'b0;
      reset = 1'b0;
      #2;
      total++;
      if ({ACC_oValid, ACC_oReady, ACC_oSum, ACC_oMean, ACC_oCount} !== '0) begin
         bad++;
         $display("FAIL reset_async: valid=%b ready=%b sum=%h mean=%h count=%h, want all 0",
                  ACC_oValid, ACC_oReady, ACC_oSum, ACC_oMean, ACC_oCount);
      end
      reset = 1'b1;
      step();
      foreach (smp[i]) begin smp[i] = 2; gap[i] = 0; end
      run_window(smp, gap, 1'b1);
      check_result(e);
      release_to_idle();
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b0;
      ACC_iStart = 1'b0;
      ACC_iValid = 1'b0;
      ACC_iData  = '0;
      ACC_iReady = 1'b0;
      test_reset();
      test_ones();
      test_extremes();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d results left, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
